// File: rtl/req_encoder16.sv
// Sixteen-line request encoder: sticky pending register feeding a valid/ack index presenter.
// Latency: req in cycle N -> pending in N+1 -> valid/index in N+2; one grant per 2 cycles max.
// Backpressure: index/valid held indefinitely until ack; new requests keep accumulating meanwhile.
//
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset
//   en       - request capture enable (0 = ignore req, service continues)
//   req      - request lines, req[i] requests index i
//   ack      - consumer accepts the presented index (only meaningful while valid)
//   index    - granted index, index[0] is MSB
//   valid    - index is valid and stable
//   pending  - registered pending-request vector
//   busy     - pending != 0 or valid
module req_encoder16 #(
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [0:15] req,
  input  logic        ack,
  output logic [0:3]  index,
  output logic        valid,
  output logic [0:15] pending,
  output logic        busy
);

  typedef enum logic {
    ST_IDLE,
    ST_PRESENT
  } state_t;

  state_t      r_state;
  logic [3:0]  r_index;
  logic        r_valid;
  logic [0:15] r_pending;
  logic [3:0]  r_last;

  logic [0:15] w_clr;
  logic [0:15] w_pending_next;
  logic [3:0]  w_start;
  logic [3:0]  w_cand;
  logic [3:0]  w_sel;

  // Clear only the line whose handshake completes this cycle.
  always_comb begin
    w_clr = '0;
    if (r_valid && ack) begin
      w_clr[r_index] = 1'b1;
    end
  end

  // Set wins over clear: a fresh request on the acked line keeps it pending.
  assign w_pending_next = (r_pending & ~w_clr) | (en ? req : 16'b0);

  // Winner search over the registered pending vector. Scanning offsets from
  // high to low lets the smallest offset from the start point win.
  always_comb begin
    w_start = ROUND_ROBIN ? (r_last + 4'd1) : 4'd0;
    w_sel   = 4'd0;
    w_cand  = 4'd0;
    for (int k = 15; k >= 0; k--) begin
      w_cand = w_start + 4'(k);
      if (r_pending[w_cand]) begin
        w_sel = w_cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_index   <= 4'd0;
      r_valid   <= 1'b0;
      r_pending <= '0;
      r_last    <= 4'd15;  // first rotating search starts at line 0
    end else begin
      r_pending <= w_pending_next;
      case (r_state)
        ST_IDLE: begin
          if (|r_pending) begin
            r_index <= w_sel;
            r_valid <= 1'b1;
            r_state <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (ack) begin
            r_valid <= 1'b0;
            r_last  <= r_index;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign index   = r_index;
  assign valid   = r_valid;
  assign pending = r_pending;
  assign busy    = (|r_pending) | r_valid;

endmodule

// File: tb/tb_req_encoder16.sv
module tb_req_encoder16;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [0:15] req_s     [2];
  logic        ack_s     [2];
  logic [0:3]  index_o   [2];
  logic        valid_o   [2];
  logic [0:15] pending_o [2];
  logic        busy_o    [2];

  int n_vec;
  int n_bad;

  logic [3:0] q0[$];
  logic [3:0] q1[$];
  bit gap0;
  bit gap1;

  // Instance 0: fixed priority. Instance 1: round robin.
  req_encoder16 #(.ROUND_ROBIN(1'b0)) u_fp (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req_s[0]), .ack(ack_s[0]),
    .index(index_o[0]), .valid(valid_o[0]), .pending(pending_o[0]), .busy(busy_o[0])
  );

  req_encoder16 #(.ROUND_ROBIN(1'b1)) u_rr (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req_s[1]), .ack(ack_s[1]),
    .index(index_o[1]), .valid(valid_o[1]), .pending(pending_o[1]), .busy(busy_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Bit i of m is request line i.
  function automatic logic [0:15] lines(input logic [15:0] m);
    logic [0:15] r;
    for (int i = 0; i < 16; i++) r[i] = m[i];
    return r;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic push(input int d, input logic [3:0] v);
    if (d == 0) q0.push_back(v);
    else        q1.push_back(v);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int d, input logic [15:0] m);
    req_s[d] = lines(m);
    cyc();
    req_s[d] = '0;
  endtask

  task automatic drain(input int d, input int budget);
    int t;
    t = 0;
    while ((qsize(d) != 0 || busy_o[d]) && t < budget) begin
      cyc();
      t++;
    end
    chk($sformatf("drain%0d_timeout", d), (t >= budget) ? 32'd1 : 32'd0, 32'd0);
  endtask

  // Scoreboards: a handshake is seen at the negedge before the completing edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (gap0) chk("gap0_valid_low", {31'd0, valid_o[0]}, 32'd0);
      gap0 = 1'b0;
      if (valid_o[0] && ack_s[0]) begin
        if (q0.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL grant0: got %0d, expected no grant", index_o[0]);
        end else begin
          chk("grant0", {28'd0, index_o[0]}, {28'd0, q0.pop_front()});
        end
        gap0 = 1'b1;
      end
    end else begin
      gap0 = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (gap1) chk("gap1_valid_low", {31'd0, valid_o[1]}, 32'd0);
      gap1 = 1'b0;
      if (valid_o[1] && ack_s[1]) begin
        if (q1.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL grant1: got %0d, expected no grant", index_o[1]);
        end else begin
          chk("grant1", {28'd0, index_o[1]}, {28'd0, q1.pop_front()});
        end
        gap1 = 1'b1;
      end
    end else begin
      gap1 = 1'b0;
    end
  end

  typedef struct {
    logic [15:0]      m;
    int               n;
    logic [0:3][3:0]  ord;
  } vec_t;

  vec_t vt [5];

  initial begin
    n_vec = 0;
    n_bad = 0;
    gap0  = 1'b0;
    gap1  = 1'b0;

    vt[0] = '{16'h0020, 1, {4'd5,  4'd0,  4'd0,  4'd0}};
    vt[1] = '{16'h8208, 3, {4'd3,  4'd9,  4'd15, 4'd0}};
    vt[2] = '{16'h8001, 2, {4'd0,  4'd15, 4'd0,  4'd0}};
    vt[3] = '{16'h4182, 4, {4'd1,  4'd7,  4'd8,  4'd14}};
    vt[4] = '{16'h1C00, 3, {4'd10, 4'd11, 4'd12, 4'd0}};

    // Reset with all requests asserted
    rst_n    = 1'b0;
    en       = 1'b1;
    req_s[0] = 16'hFFFF;
    req_s[1] = 16'hFFFF;
    ack_s[0] = 1'b0;
    ack_s[1] = 1'b0;
    repeat (3) cyc();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_index%0d", d),   {28'd0, index_o[d]}, 32'd0);
      chk($sformatf("rst_valid%0d", d),   {31'd0, valid_o[d]}, 32'd0);
      chk($sformatf("rst_pending%0d", d), {16'd0, pending_o[d]}, 32'd0);
      chk($sformatf("rst_busy%0d", d),    {31'd0, busy_o[d]}, 32'd0);
    end
    req_s[0] = '0;
    req_s[1] = '0;
    rst_n    = 1'b1;
    cyc();

    // Single request: line 5, latency and handshake
    pulse(0, 16'h0020);
    chk("single_pend_n1",  {16'd0, pending_o[0]}, {16'd0, lines(16'h0020)});
    chk("single_valid_n1", {31'd0, valid_o[0]}, 32'd0);
    cyc();
    chk("single_valid_n2", {31'd0, valid_o[0]}, 32'd1);
    chk("single_index_n2", {28'd0, index_o[0]}, 32'd5);
    chk("single_busy_n2",  {31'd0, busy_o[0]}, 32'd1);
    cyc();
    push(0, 4'd5);
    ack_s[0] = 1'b1;
    cyc();
    ack_s[0] = 1'b0;
    chk("single_valid_n4", {31'd0, valid_o[0]}, 32'd0);
    chk("single_pend_n4",  {16'd0, pending_o[0]}, 32'd0);
    chk("single_busy_n4",  {31'd0, busy_o[0]}, 32'd0);

    // Enable low ignores requests
    en       = 1'b0;
    req_s[0] = lines(16'h00FF);
    cyc();
    cyc();
    chk("en0_pending", {16'd0, pending_o[0]}, 32'd0);
    chk("en0_busy",    {31'd0, busy_o[0]}, 32'd0);
    req_s[0] = '0;
    en       = 1'b1;

    // Hold without ack for 10 cycles
    pulse(0, 16'h0010);
    cyc();
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", {31'd0, valid_o[0]}, 32'd1);
      chk("hold_index", {28'd0, index_o[0]}, 32'd4);
      cyc();
    end
    push(0, 4'd4);
    ack_s[0] = 1'b1;
    cyc();
    // ack while idle must do nothing
    for (int i = 0; i < 3; i++) begin
      chk("idle_ack_valid", {31'd0, valid_o[0]}, 32'd0);
      chk("idle_ack_pend",  {16'd0, pending_o[0]}, 32'd0);
      cyc();
    end
    ack_s[0] = 1'b0;

    // Set wins over clear on the acked line
    pulse(0, 16'h0040);
    cyc();
    chk("setwin_index", {28'd0, index_o[0]}, 32'd6);
    push(0, 4'd6);
    push(0, 4'd6);
    ack_s[0] = 1'b1;
    req_s[0] = lines(16'h0040);
    cyc();
    req_s[0] = '0;
    chk("setwin_valid_gap", {31'd0, valid_o[0]}, 32'd0);
    chk("setwin_pending",   {16'd0, pending_o[0]}, {16'd0, lines(16'h0040)});
    cyc();
    chk("setwin_regrant_valid", {31'd0, valid_o[0]}, 32'd1);
    chk("setwin_regrant_index", {28'd0, index_o[0]}, 32'd6);
    cyc();
    ack_s[0] = 1'b0;
    chk("setwin_busy_end", {31'd0, busy_o[0]}, 32'd0);

    // Fixed-priority table, ack held high
    ack_s[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < vt[i].n; k++) push(0, vt[i].ord[k]);
      pulse(0, vt[i].m);
      chk("fp_capture", {16'd0, pending_o[0]}, {16'd0, lines(vt[i].m)});
      drain(0, 60);
    end
    ack_s[0] = 1'b0;

    // Async reset while presenting
    pulse(0, 16'h0200);
    cyc();
    chk("midrst_pre_valid", {31'd0, valid_o[0]}, 32'd1);
    chk("midrst_pre_index", {28'd0, index_o[0]}, 32'd9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid",   {31'd0, valid_o[0]}, 32'd0);
    chk("midrst_pending", {16'd0, pending_o[0]}, 32'd0);
    chk("midrst_busy",    {31'd0, busy_o[0]}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc();

    // Round robin with two continuously asserted lines
    for (int i = 0; i < 3; i++) begin
      push(1, 4'd2);
      push(1, 4'd14);
    end
    req_s[1] = lines(16'h4004);
    ack_s[1] = 1'b1;
    begin
      int t;
      t = 0;
      while (q1.size() != 0 && t < 60) begin
        cyc();
        t++;
      end
      chk("rr_alt_timeout", (t >= 60) ? 32'd1 : 32'd0, 32'd0);
    end
    ack_s[1] = 1'b0;
    req_s[1] = '0;
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();

    // Round robin ordering and wrap
    ack_s[1] = 1'b1;
    push(1, 4'd7);
    pulse(1, 16'h0080);
    drain(1, 40);
    push(1, 4'd9);
    push(1, 4'd3);
    pulse(1, 16'h0208);
    drain(1, 40);
    push(1, 4'd15);
    pulse(1, 16'h8000);
    drain(1, 40);
    push(1, 4'd0);
    push(1, 4'd7);
    pulse(1, 16'h0081);
    drain(1, 40);
    ack_s[1] = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/req_encoder16.md
# req_encoder16

Sixteen-line request encoder with a valid/ack handshake: the inverse of the RAM address decoder. It collects one-hot or multi-hot request lines into a pending register and emits the 4-bit index of one pending line at a time, holding it until acknowledged, then clearing that line. It sits between peripheral/word-line request sources and the control unit, turning line requests back into addresses.

## Interface
- ROUND_ROBIN, 0: 0 gives fixed priority, lowest index wins. 1 gives rotating priority, where the search starts one past the last granted index.
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous reset, active-low (one clock; reset is asynchronous and active-low)
- en  input  1  request capture enable; when 0, new requests are ignored
- req  input  [0:15]  request lines; req[i] requests index i (req[0] is index 0000)
- ack  input  1  consumer accepts the current index; meaningful only while valid=1
- index  output  [0:3]  granted index, index[0] is MSB (decoder address order)
- valid  output  1  index is valid and stable
- pending  output  [0:15]  registered pending-request vector
- busy  output  1  high when pending != 0 or valid=1

## Operation
- Pending update every cycle: pending_next = (pending & ~clr) | (en ? req : 16'b0).
  - clr is the one-hot of index when valid & ack, else 0.
  - Set wins: a req on the line being acked in the same cycle keeps that bit pending.
- FSM has two states:
  - IDLE: valid=0. If pending != 0, select a winner from registered pending (not raw req), load index, and go to PRESENT. Otherwise stay in IDLE.
  - PRESENT: valid=1 and index is held stable. On ack, clear pending[index] and return to IDLE. Without ack, stay in PRESENT indefinitely.
- Selection when ROUND_ROBIN=0: smallest i with pending[i]=1.
- Selection when ROUND_ROBIN=1:
  - Choose the first i with pending[i]=1, scanning last+1, last+2, … mod 16 (wraps 15→0).
  - last is updated to index on each ack.
- ack while valid=0 has no effect.
- en=0 does not stall service: already-pending lines continue to be granted.
- Requests are sticky: a 1-cycle req pulse is enough and stays pending until granted.
- Reset (async assert, rst_n low) sets:
  - state=IDLE, valid=0, index=0000, pending=0, last=15 (first RR search starts at 0).
  - busy=0.
- Reset assertion mid-handshake drops the grant and all pending bits immediately. No ack is required afterwards.

## Timing
- Latency: req sampled at edge E, pending set after E, index/valid set after E+1. Request high in cycle N gives valid in cycle N+2.
- Handshake completes at the edge where valid & ack. valid is low for at least 1 cycle after each ack (IDLE re-evaluation).
- Maximum throughput is one grant per 2 cycles when ack is tied high.
- index changes only on the IDLE→PRESENT transition, and is never altered while valid=1.
- busy is combinational from registered state (pending, valid); no combinational path from req or ack to any output.
- Reset deassertion: first capture at the first rising edge with rst_n=1.

## Test plan
- Reset: drive rst_n=0 with req=16'hFFFF and en=1. Required: index=0000, valid=0, pending=0, busy=0. Also assert rst_n low mid-PRESENT and require valid to drop asynchronously.
- Single request: pulse req[5] for 1 cycle with en=1 at cycle N. Required: pending[5]=1 at N+1, valid=1 with index=0101 at N+2. Ack at N+3 gives valid=0 and pending=0 at N+4.
- Fixed priority (ROUND_ROBIN=0): pending={3,9,15}, ack held high. Required grant order 0011, 1001, 1111, with valid low 1 cycle between grants, then busy=0.
- Round robin (ROUND_ROBIN=1): keep req[2] and req[14] asserted continuously, ack high. Required order 0010, 1110, 0010, 1110… and no starvation. Separately, grant 15 then pending={0,7} gives 0000 first (wrap).
- Set-wins: while index=0110 is valid, assert ack and req[6] together. Required: pending[6] stays 1 and index=0110 is re-granted 2 cycles later.
- Enable and hold: en=0 with req=16'h00FF gives no pending. Then with pending[4] already set and ack=0 held for 10 cycles, index=0100 stays constant with valid=1, and an ack while valid=0 changes nothing.
